// File: rtl/wb_dma_pkg.sv
// wb_dma_pkg: register map, CTRL/STATUS bit indices and FSM encoding for wb_dma
package wb_dma_pkg;
  localparam logic [2:0] REG_SRC    = 3'd0;
  localparam logic [2:0] REG_DST    = 3'd1;
  localparam logic [2:0] REG_LEN    = 3'd2;
  localparam logic [2:0] REG_CTRL   = 3'd3;
  localparam logic [2:0] REG_STATUS = 3'd4;
  localparam int CTRL_START  = 0;
  localparam int CTRL_IRQ_EN = 1;
  localparam int CTRL_ABORT  = 2;
  localparam int ST_BUSY = 0;
  localparam int ST_DONE = 1;
  localparam int ST_ERR  = 2;
  localparam int ST_TMO  = 3;
  typedef enum logic [1:0] {IDLE = 2'd0, RD = 2'd1, WR = 2'd2, FIN = 2'd3} state_t;
endpackage

// File: rtl/wb_dma_regs.sv
// wb_dma_regs: slave register file with one-cycle ack, start/abort pulses and sticky status
module wb_dma_regs
  import wb_dma_pkg::*;
#(
  parameter int len_w = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [31:0]      wb_adr_i,
  input  logic [31:0]      wb_dat_i,
  output logic [31:0]      wb_dat_o,
  input  logic [3:0]       wb_sel_i,
  input  logic             wb_we_i,
  input  logic             wb_cyc_i,
  input  logic             wb_stb_i,
  output logic             wb_ack_o,
  input  logic             busy,
  input  logic             done_set,
  input  logic             err_set,
  input  logic             tmo_set,
  input  logic [len_w-1:0] remaining,
  output logic [31:0]      src,
  output logic [31:0]      dst,
  output logic [len_w-1:0] len,
  output logic             start,
  output logic             abort,
  output logic             irq
);
  logic req, wr, clr, irq_en, done, err, tmo, unused;
  logic [2:0] sel;
  logic [31:0] rdata;
  assign req = wb_cyc_i & wb_stb_i & ~wb_ack_o;
  assign wr = req & wb_we_i;
  assign sel = wb_adr_i[4:2];
  assign clr = wr & sel == REG_STATUS;
  assign unused = ^{wb_adr_i[31:5], wb_adr_i[1:0], wb_sel_i};
  assign rdata = sel == REG_SRC    ? src :
                 sel == REG_DST    ? dst :
                 sel == REG_LEN    ? 32'(len) :
                 sel == REG_CTRL   ? {30'b0, irq_en, 1'b0} :
                 sel == REG_STATUS ? {16'(remaining), 12'b0, tmo, err, done, busy} : 32'b0;
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      wb_ack_o <= 1'b0;
      wb_dat_o <= 32'b0;
      src <= 32'b0;
      dst <= 32'b0;
      len <= '0;
      start <= 1'b0;
      abort <= 1'b0;
      irq_en <= 1'b0;
      done <= 1'b0;
      err <= 1'b0;
      tmo <= 1'b0;
      irq <= 1'b0;
    end else begin
      wb_ack_o <= req;
      wb_dat_o <= req ? rdata : 32'b0;
      start <= wr & sel == REG_CTRL & wb_dat_i[CTRL_START];
      abort <= wr & sel == REG_CTRL & wb_dat_i[CTRL_ABORT];
      if (wr & sel == REG_CTRL) irq_en <= wb_dat_i[CTRL_IRQ_EN];
      if (wr & ~busy & sel == REG_SRC) src <= wb_dat_i;
      if (wr & ~busy & sel == REG_DST) dst <= wb_dat_i;
      if (wr & ~busy & sel == REG_LEN) len <= wb_dat_i[len_w-1:0];
      // a completion landing on the same edge as a clear must not be lost
      done <= done_set | done & ~(clr & wb_dat_i[ST_DONE]);
      err <= err_set | err & ~(clr & wb_dat_i[ST_ERR]);
      tmo <= tmo_set | tmo & ~(clr & wb_dat_i[ST_TMO]);
      irq <= irq_en & (done | err);
    end
endmodule

// File: rtl/wb_dma.sv
// wb_dma: Wishbone block-copy DMA master; define WB_DMA_TIMEOUT_EN for a per-beat ack watchdog
module wb_dma
  import wb_dma_pkg::*;
#(
  parameter int len_w = 16,
  parameter int timeout_cycles = 1024
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] wb_adr_i,
  input  logic [31:0] wb_dat_i,
  output logic [31:0] wb_dat_o,
  input  logic [3:0]  wb_sel_i,
  input  logic        wb_we_i,
  input  logic        wb_cyc_i,
  input  logic        wb_stb_i,
  output logic        wb_ack_o,
  output logic [31:0] m_adr_o,
  output logic [31:0] m_dat_o,
  input  logic [31:0] m_dat_i,
  output logic [3:0]  m_sel_o,
  output logic        m_we_o,
  output logic        m_cyc_o,
  output logic        m_stb_o,
  input  logic        m_ack_i,
  input  logic        m_err_i,
  output logic        irq
);
  state_t state, state_n;
  logic [31:0] src_q, dst_q, buf_q, src_r, dst_r;
  logic [len_w-1:0] cnt, len_r;
  logic gap, abort_pend, beat, ack, fail, last, tmo;
  logic start, abort, busy, done_set;
  wb_dma_regs #(.len_w(len_w)) u_regs (
    .clk(clk), .rst(rst),
    .wb_adr_i(wb_adr_i), .wb_dat_i(wb_dat_i), .wb_dat_o(wb_dat_o), .wb_sel_i(wb_sel_i),
    .wb_we_i(wb_we_i), .wb_cyc_i(wb_cyc_i), .wb_stb_i(wb_stb_i), .wb_ack_o(wb_ack_o),
    .busy(busy), .done_set(done_set), .err_set(fail), .tmo_set(tmo), .remaining(cnt),
    .src(src_r), .dst(dst_r), .len(len_r), .start(start), .abort(abort), .irq(irq)
  );
  // gap holds cyc/stb low for the cycle after every ack so the arbiter can switch masters
  assign beat = (state == RD | state == WR) & ~gap;
  assign fail = beat & (m_err_i | tmo);
  assign ack = beat & m_ack_i & ~fail;
  assign last = cnt == len_w'(1) | abort_pend | abort;
  assign busy = state != IDLE;
  assign done_set = fail | state == FIN | (state == IDLE & start & len_r == '0);
  assign m_cyc_o = beat;
  assign m_stb_o = beat;
  assign m_we_o = beat & state == WR;
  assign m_adr_o = state == WR ? dst_q : src_q;
  assign m_dat_o = buf_q;
  assign m_sel_o = 4'hF;
`ifdef WB_DMA_TIMEOUT_EN
  localparam int tw = $clog2(timeout_cycles + 1);
  logic [tw-1:0] tcnt;
  assign tmo = beat & ~m_ack_i & ~m_err_i & tcnt == tw'(timeout_cycles - 1);
  always_ff @(posedge clk or posedge rst)
    if (rst) tcnt <= '0;
    else tcnt <= beat & ~m_ack_i & ~m_err_i ? tcnt + tw'(1) : '0;
`else
  logic unused_tmo;
  assign tmo = 1'b0;
  assign unused_tmo = timeout_cycles == 0;
`endif
  always_comb begin
    state_n = state;
    case (state)
      IDLE: state_n = start & len_r != '0 ? RD : IDLE;
      RD:   state_n = fail ? IDLE : ack ? WR : RD;
      WR:   state_n = fail ? IDLE : ~ack ? WR : last ? FIN : RD;
      FIN:  state_n = IDLE;
    endcase
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state <= IDLE;
      src_q <= 32'b0;
      dst_q <= 32'b0;
      buf_q <= 32'b0;
      cnt <= '0;
      gap <= 1'b0;
      abort_pend <= 1'b0;
    end else begin
      state <= state_n;
      gap <= ack;
      abort_pend <= busy & (abort_pend | abort);
      if (state == IDLE & start) begin
        src_q <= src_r;
        dst_q <= dst_r;
        cnt <= len_r;
      end
      if (ack & state == RD) begin
        buf_q <= m_dat_i;
        src_q <= src_q + 32'd4;
      end
      if (ack & state == WR) begin
        dst_q <= dst_q + 32'd4;
        cnt <= cnt - len_w'(1);
      end
    end
endmodule

// File: doc/wb_dma.md
Name: wb_dma

Overview:
- Wishbone bus master: copies a block of 32-bit words from a source address to a destination address on the conbus fabric, so the LM32 does not spend cycles on bulk transfers.
- Has two bus ports:
  - Wishbone slave port for configuration by the CPU, placed in a free conbus slot (e.g. 0x80000000).
  - Wishbone master port attached as an additional conbus master.
- Raises an interrupt line on completion.

Parameters:
- len_w, 16, width of the LEN register (maximum transfer length in words is 2^len_w - 1).
- timeout_cycles, 1024, per-beat ack watchdog limit; used only with WB_DMA_TIMEOUT_EN.

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous reset, active-high.
- wb_adr_i  in  32  slave address; register select is wb_adr_i[4:2].
- wb_dat_i  in  32  slave write data.
- wb_dat_o  out  32  slave read data.
- wb_sel_i  in  4  slave byte enables; ignored, all accesses are treated as full-word.
- wb_we_i  in  1  slave write enable.
- wb_cyc_i  in  1  slave cycle.
- wb_stb_i  in  1  slave strobe.
- wb_ack_o  out  1  slave acknowledge.
- m_adr_o  out  32  master address.
- m_dat_o  out  32  master write data.
- m_dat_i  in  32  master read data.
- m_sel_o  out  4  master byte enables; always 4'hF.
- m_we_o  out  1  master write enable.
- m_cyc_o  out  1  master cycle.
- m_stb_o  out  1  master strobe.
- m_ack_i  in  1  master acknowledge.
- m_err_i  in  1  master bus error.
- irq  out  1  interrupt, active-high level.

Behaviour:
- Reset: one clock (clk), asynchronous active-high reset (rst). While rst is high, every output and register is 0, the FSM is in IDLE and m_sel_o is 4'hF. Assertion of rst mid-transfer drops m_cyc_o and m_stb_o immediately, without waiting for ack.
- Register map (byte offsets):
  - 0x00 SRC, read/write.
  - 0x04 DST, read/write.
  - 0x08 LEN, read/write, len_w bits, zero-extended on read.
  - 0x0C CTRL. Write bit0 = START (self-clearing), bit1 = IRQ_EN (stored), bit2 = ABORT (self-clearing). Reads return {30'b0, IRQ_EN, 1'b0}.
  - 0x10 STATUS. bit0 BUSY (read-only), bit1 DONE (sticky, write 1 to clear), bit2 ERR (sticky, write 1 to clear), bits[31:16] = words remaining.
  - Other offsets read 0; writes to them are ignored.
- Slave handshake:
  - wb_ack_o pulses for exactly one cycle, one cycle after wb_cyc_i & wb_stb_i & ~wb_ack_o.
  - wb_dat_o is valid in the same cycle as the ack.
  - Writes to SRC, DST and LEN while BUSY are ignored.
- FSM states: IDLE, RD, WR, FIN.
  - IDLE: on START with LEN != 0, load working copies of src, dst and count, set BUSY, go to RD.
  - IDLE: on START with LEN == 0, set DONE the next cycle; no bus activity.
  - IDLE: START while BUSY is ignored.
  - RD: drive m_cyc_o=1, m_stb_o=1, m_we_o=0, m_adr_o=src. On m_ack_i, latch m_dat_i into the data buffer, deassert stb/cyc for one cycle, then go to WR. src increments by 4, with 32-bit wrap (0xFFFFFFFC -> 0).
  - WR: drive m_cyc_o=1, m_stb_o=1, m_we_o=1, m_adr_o=dst, m_dat_o=buffer. On m_ack_i, dst increments by 4 and count decrements. If count reaches 0 or an abort is pending, go to FIN; otherwise go to RD.
  - FIN: clear BUSY, set DONE, return to IDLE.
- Master signal rules:
  - Signals stay stable while m_stb_o is high and ack is not yet received.
  - The master never drops stb mid-beat except on reset.
  - m_cyc_o and m_stb_o are both low for at least one cycle between beats, giving the arbiter a turn.
- ABORT: takes effect at the next beat boundary; a write already in flight completes. Sets DONE, not ERR.
- m_err_i during RD or WR: terminates the beat, sets ERR and DONE, returns to IDLE. An err received during RD skips the write.
- Simultaneous m_ack_i and m_err_i: err wins.
- irq = IRQ_EN & (DONE | ERR), registered.
- Throughput: at least 2 beats per word, plus 1 idle cycle per beat, plus slave latency.

Optional Feature:
- WB_DMA_TIMEOUT_EN defined: a per-beat counter starts when stb rises. If timeout_cycles elapse without ack or err, the beat is aborted: cyc/stb drop, ERR and DONE are set, FSM returns to IDLE. STATUS bit3 (TMO, sticky, write 1 to clear) is also set.
- WB_DMA_TIMEOUT_EN undefined: no counter, a beat waits indefinitely, and STATUS bit3 reads 0.

Decomposition:
- Package wb_dma_pkg holds:
  - register offset constants (REG_SRC, REG_DST, REG_LEN, REG_CTRL, REG_STATUS);
  - CTRL and STATUS bit indices;
  - FSM state encoding constants.
- Natural sub-module: wb_dma_regs, the slave register file with ack generation, exposing start/abort pulses and config values to the master FSM in wb_dma.

Test Plan:
- Basic copy: SRC=0x100, DST=0x200, LEN=4, START. Memory model acks after 2 cycles. Expect 4 reads at 0x100..0x10C alternating with 4 writes at 0x200..0x20C, data matches, then DONE=1 and BUSY=0. With IRQ_EN=1, irq=1; writing STATUS=0x2 clears DONE and irq.
- Zero length: LEN=0, START. Expect m_cyc_o low throughout and DONE=1 within 2 cycles.
- Bus error: err on the 2nd read of a LEN=3 transfer. Expect the 2nd write is skipped, ERR=1, DONE=1, STATUS[31:16]=2.
- Abort: ABORT written during the 3rd write of a LEN=8 transfer. Expect that write to complete, no further beats, and remaining=5.
- Reset mid-beat: rst asserted while m_stb_o=1. Expect m_cyc_o, m_stb_o and irq low in the same cycle, and all registers reading 0 afterwards.
- Address wrap plus timeout (WB_DMA_TIMEOUT_EN, timeout_cycles=16): SRC=0xFFFFFFFC, LEN=2. Expect the 2nd read at 0x00000000. A slave that never acks aborts the beat after 16 cycles with ERR=1 and TMO=1.
